nabu_kbd: RTL and testbench

NABU_KBD -- requirements
Module: nabu_kbd

---
 rtl/nabu_kbd.sv | 216 +++++++++++++++++++++
 tb/tb_nabu_kbd.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nabu_kbd.sv
// nabu_kbd: NABU keyboard controller.
// Turns MiSTer hps_io PS/2 set-2 key events into NABU ASCII bytes. The bytes
// are queued in a receive FIFO that the Z80 reads through I/O ports 0x90
// (data) and 0x91 (status). A 0x95 keep-alive byte is queued every
// HEARTBEAT_CYCLES clocks.
//
// Ports:
//   clk_sys  - system clock; all state changes on its rising edge
//   reset_n  - asynchronous active-low reset
//   ps2_key  - [10] toggle strobe, [9] pressed, [8] extended, [7:0] scan code
//   io_addr  - Z80 I/O address A[7:0]
//   io_rd    - I/O read strobe (level, may span several cycles)
//   io_wr    - I/O write strobe (level, may span several cycles)
//   io_din   - CPU write data
//   io_dout  - read data for ports 0x90/0x91, 0x00 when io_oe is low
//   io_oe    - high while a read addresses port 0x90 or 0x91
//   int_req  - high while the receive FIFO holds at least one byte
module nabu_kbd #(
   parameter int FIFO_DEPTH       = 8,
   parameter int HEARTBEAT_CYCLES = 159056712
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic [10:0] ps2_key,
   input  logic [7:0]  io_addr,
   input  logic        io_rd,
   input  logic        io_wr,
   input  logic [7:0]  io_din,
   output logic [7:0]  io_dout,
   output logic        io_oe,
   output logic        int_req
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int HW = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;
   localparam logic [HW-1:0] HB_LAST = HW'(HEARTBEAT_CYCLES - 1);
   localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);

   logic          primed;
   logic          key_tgl_q;
   logic          ev_valid, ev_pressed, ev_ext;
   logic [7:0]    ev_code;
   logic          shift_q;
   logic [7:0]    plain, shifted, ext_byte, xlat_byte;
   logic          xlat_hit;
   logic          tr_valid;
   logic [7:0]    tr_byte;
   logic [HW-1:0] hb_cnt;
   logic          hb_wrap, hb_req, hb_pend;
   logic          push;
   logic [7:0]    push_byte;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          full, not_empty, do_push, pop, overrun;
   logic          rd_idle, wr_idle, acc90, acc91_clr, ovr_clear;
   logic          addr90, addr91;

   // Event capture. The first cycle after reset only copies the toggle bit so
   // a stale toggle level is never mistaken for a new key event.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         primed     <= 1'b0;
         key_tgl_q  <= 1'b0;
         ev_valid   <= 1'b0;
         ev_pressed <= 1'b0;
         ev_ext     <= 1'b0;
         ev_code    <= 8'h00;
      end else begin
         primed     <= 1'b1;
         key_tgl_q  <= ps2_key[10];
         ev_valid   <= primed && (ps2_key[10] != key_tgl_q);
         ev_pressed <= ps2_key[9];
         ev_ext     <= ps2_key[8];
         ev_code    <= ps2_key[7:0];
      end
   end

   // Scan code to NABU byte. Letters only list their lower-case form; the
   // upper-case form is derived. A zero result means "no byte for this code".
   always_comb begin
      plain    = 8'h00;
      shifted  = 8'h00;
      ext_byte = 8'h00;
      case (ev_code)
         8'h1C: plain = "a";   8'h32: plain = "b";   8'h21: plain = "c";
         8'h23: plain = "d";   8'h24: plain = "e";   8'h2B: plain = "f";
         8'h34: plain = "g";   8'h33: plain = "h";   8'h43: plain = "i";
         8'h3B: plain = "j";   8'h42: plain = "k";   8'h4B: plain = "l";
         8'h3A: plain = "m";   8'h31: plain = "n";   8'h44: plain = "o";
         8'h4D: plain = "p";   8'h15: plain = "q";   8'h2D: plain = "r";
         8'h1B: plain = "s";   8'h2C: plain = "t";   8'h3C: plain = "u";
         8'h2A: plain = "v";   8'h1D: plain = "w";   8'h22: plain = "x";
         8'h35: plain = "y";   8'h1A: plain = "z";
         8'h16: begin plain = "1"; shifted = "!"; end
         8'h1E: begin plain = "2"; shifted = "@"; end
         8'h26: begin plain = "3"; shifted = "#"; end
         8'h25: begin plain = "4"; shifted = "$"; end
         8'h2E: begin plain = "5"; shifted = "%"; end
         8'h36: begin plain = "6"; shifted = "^"; end
         8'h3D: begin plain = "7"; shifted = "&"; end
         8'h3E: begin plain = "8"; shifted = "*"; end
         8'h46: begin plain = "9"; shifted = "("; end
         8'h45: begin plain = "0"; shifted = ")"; end
         8'h29: begin plain = 8'h20; shifted = 8'h20; end
         8'h5A: begin plain = 8'h0D; shifted = 8'h0D; end
         8'h66: begin plain = 8'h7F; shifted = 8'h7F; end
         8'h76: begin plain = 8'h1B; shifted = 8'h1B; end
         default: ;
      endcase
      if (plain >= "a" && plain <= "z") shifted = plain - 8'h20;
      case (ev_code)
         8'h74: ext_byte = 8'hE0;
         8'h6B: ext_byte = 8'hE1;
         8'h75: ext_byte = 8'hE2;
         8'h72: ext_byte = 8'hE3;
         default: ;
      endcase
      if (ev_ext) xlat_byte = ext_byte;
      else        xlat_byte = shift_q ? shifted : plain;
      xlat_hit = (xlat_byte != 8'h00);
   end

   // Translation register and shift tracking. Only presses of mapped codes
   // produce a byte; shift events only move the shift flag.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         tr_valid <= 1'b0;
         tr_byte  <= 8'h00;
         shift_q  <= 1'b0;
      end else begin
         tr_valid <= ev_valid && ev_pressed && xlat_hit;
         tr_byte  <= xlat_byte;
         if (ev_valid && !ev_ext && (ev_code == 8'h12 || ev_code == 8'h59))
            shift_q <= ev_pressed;
      end
   end

   // Heartbeat. A wrap that lands on a key-byte write is held one cycle so
   // the key byte goes in first and 0x95 follows.
   assign hb_wrap   = (hb_cnt == HB_LAST);
   assign hb_req    = hb_wrap || hb_pend;
   assign push      = tr_valid || hb_req;
   assign push_byte = tr_valid ? tr_byte : 8'h95;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         hb_cnt  <= '0;
         hb_pend <= 1'b0;
      end else begin
         hb_cnt  <= hb_wrap ? '0 : hb_cnt + 1'b1;
         hb_pend <= hb_req && tr_valid;
      end
   end

   // CPU strobe tracking. An access only counts once its strobe has been seen
   // low after reset, so a transfer cut by reset never pops or clears later.
   assign addr90    = (io_addr == 8'h90);
   assign addr91    = (io_addr == 8'h91);
   assign pop       = acc90 && !io_rd && not_empty;
   assign ovr_clear = acc91_clr && !io_wr;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         rd_idle   <= 1'b0;
         wr_idle   <= 1'b0;
         acc90     <= 1'b0;
         acc91_clr <= 1'b0;
      end else begin
         rd_idle   <= rd_idle || !io_rd;
         wr_idle   <= wr_idle || !io_wr;
         acc90     <= io_rd && addr90 && rd_idle;
         acc91_clr <= io_wr && addr91 && io_din[4] && wr_idle;
      end
   end

   // FIFO control. A push into a full FIFO succeeds only when a pop frees a
   // slot in the same cycle; otherwise the byte is lost and overrun latches.
   assign not_empty = (count != '0);
   assign full      = (count == DEPTH_C);
   assign do_push   = push && (!full || pop);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         overrun <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !pop)      count <= count + 1'b1;
         else if (!do_push && pop) count <= count - 1'b1;
         if (ovr_clear) overrun <= 1'b0;
         if (push && full && !pop) overrun <= 1'b1;
      end
   end

   // FIFO storage needs no reset; pointers and count define what is valid.
   always_ff @(posedge clk_sys) begin
      if (do_push) mem[wr_ptr] <= push_byte;
   end

   // Read mux for the two ports.
   assign io_oe   = reset_n && io_rd && (addr90 || addr91);
   assign int_req = not_empty;

   always_comb begin
      io_dout = 8'h00;
      if (io_oe) begin
         if (addr90) io_dout = not_empty ? mem[rd_ptr] : 8'h00;
         else        io_dout = {3'b000, overrun, 2'b00, not_empty, 1'b1};
      end
   end

endmodule

// File: tb/tb_nabu_kbd.sv
// tb_nabu_kbd: bench for nabu_kbd. Instance 0 uses the default heartbeat
// period (never reached here); instance 1 uses a 100-cycle heartbeat to check
// ordering when a key byte and a keep-alive collide. Expected FIFO bytes go
// into a scoreboard queue when a key is driven and are compared on readout.
module tb_nabu_kbd;

   logic        clk_sys = 1'b0;
   logic        reset_n_v [2];
   logic [10:0] ps2_key_v [2];
   logic [7:0]  io_addr_v [2];
   logic        io_rd_v   [2];
   logic        io_wr_v   [2];
   logic [7:0]  io_din_v  [2];
   logic [7:0]  io_dout_v [2];
   logic        io_oe_v   [2];
   logic        int_req_v [2];

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_q [$];

   always #5 clk_sys = ~clk_sys;

   nabu_kbd u_dut (
      .clk_sys (clk_sys),
      .reset_n (reset_n_v[0]),
      .ps2_key (ps2_key_v[0]),
      .io_addr (io_addr_v[0]),
      .io_rd   (io_rd_v[0]),
      .io_wr   (io_wr_v[0]),
      .io_din  (io_din_v[0]),
      .io_dout (io_dout_v[0]),
      .io_oe   (io_oe_v[0]),
      .int_req (int_req_v[0])
   );

   nabu_kbd #(.FIFO_DEPTH(8), .HEARTBEAT_CYCLES(100)) u_hb (
      .clk_sys (clk_sys),
      .reset_n (reset_n_v[1]),
      .ps2_key (ps2_key_v[1]),
      .io_addr (io_addr_v[1]),
      .io_rd   (io_rd_v[1]),
      .io_wr   (io_wr_v[1]),
      .io_din  (io_din_v[1]),
      .io_dout (io_dout_v[1]),
      .io_oe   (io_oe_v[1]),
      .int_req (int_req_v[1])
   );

   // Flip the toggle strobe with a new event and let it settle into the FIFO.
   task automatic press_key(input int idx, input logic pressed, input logic ext,
                            input logic [7:0] code);
      @(negedge clk_sys);
      ps2_key_v[idx] = {~ps2_key_v[idx][10], pressed, ext, code};
      repeat (4) @(negedge clk_sys);
   endtask

   // Multi-cycle CPU read; data is sampled while io_rd is still high.
   task automatic cpu_read(input int idx, input logic [7:0] addr,
                           output logic [7:0] data, output logic oe);
      @(negedge clk_sys);
      io_addr_v[idx] = addr;
      io_rd_v[idx]   = 1'b1;
      @(negedge clk_sys);
      data = io_dout_v[idx];
      oe   = io_oe_v[idx];
      @(negedge clk_sys);
      io_rd_v[idx] = 1'b0;
      @(negedge clk_sys);
   endtask

   task automatic cpu_write(input int idx, input logic [7:0] addr, input logic [7:0] data);
      @(negedge clk_sys);
      io_addr_v[idx] = addr;
      io_din_v[idx]  = data;
      io_wr_v[idx]   = 1'b1;
      repeat (2) @(negedge clk_sys);
      io_wr_v[idx] = 1'b0;
      @(negedge clk_sys);
   endtask

   task automatic test_reset;
      logic [7:0] d;
      logic oe;
      io_addr_v[0] = 8'h90;
      io_rd_v[0]   = 1'b1;
      repeat (3) @(negedge clk_sys);
      total++;
      if (int_req_v[0] !== 1'b0 || io_oe_v[0] !== 1'b0 || io_dout_v[0] !== 8'h00) begin
         bad++;
         $display("[TB] FAIL reset_outputs: int_req=%b io_oe=%b io_dout=%02h, want 0 0 00",
                  int_req_v[0], io_oe_v[0], io_dout_v[0]);
      end
      io_rd_v[0]   = 1'b0;
      reset_n_v[0] = 1'b1;
      repeat (2) @(negedge clk_sys);
      cpu_read(0, 8'h91, d, oe);
      total++;
      if (d !== 8'h01 || oe !== 1'b1) begin
         bad++;
         $display("[TB] FAIL reset_status: got %02h oe=%b, want 01 oe=1", d, oe);
      end
      cpu_read(0, 8'h90, d, oe);
      total++;
      if (d !== 8'h00) begin
         bad++;
         $display("[TB] FAIL empty_read: got %02h, want 00", d);
      end
      total++;
      if (int_req_v[0] !== 1'b0) begin
         bad++;
         $display("[TB] FAIL empty_int: int_req=%b, want 0", int_req_v[0]);
      end
   endtask

   task automatic test_basic_key;
      logic [7:0] d, e;
      logic oe;
      @(negedge clk_sys);
      ps2_key_v[0] = {~ps2_key_v[0][10], 1'b1, 1'b0, 8'h1C};
      exp_q.push_back(8'h61);
      repeat (2) @(negedge clk_sys);
      total++;
      if (int_req_v[0] !== 1'b0) begin
         bad++;
         $display("[TB] FAIL int_early: int_req=%b two cycles after event, want 0", int_req_v[0]);
      end
      @(negedge clk_sys);
      total++;
      if (int_req_v[0] !== 1'b1) begin
         bad++;
         $display("[TB] FAIL int_latency: int_req=%b three cycles after event, want 1", int_req_v[0]);
      end
      cpu_read(0, 8'h90, d, oe);
      e = exp_q.pop_front();
      total++;
      if (d !== e || oe !== 1'b1) begin
         bad++;
         $display("[TB] FAIL basic_data: got %02h oe=%b, want %02h oe=1", d, oe, e);
      end
      total++;
      if (int_req_v[0] !== 1'b0) begin
         bad++;
         $display("[TB] FAIL basic_int_clear: int_req=%b, want 0", int_req_v[0]);
      end
   endtask

   task automatic test_shift;
      logic [7:0] d, e;
      logic oe;
      press_key(0, 1'b1, 1'b0, 8'h12);
      press_key(0, 1'b1, 1'b0, 8'h1C);
      exp_q.push_back(8'h41);
      press_key(0, 1'b0, 1'b0, 8'h12);
      press_key(0, 1'b1, 1'b0, 8'h1C);
      exp_q.push_back(8'h61);
      for (int i = 0; i < 2; i++) begin
         cpu_read(0, 8'h90, d, oe);
         e = exp_q.pop_front();
         total++;
         if (d !== e) begin
            bad++;
            $display("[TB] FAIL shift_data[%0d]: got %02h, want %02h", i, d, e);
         end
      end
      cpu_read(0, 8'h91, d, oe);
      total++;
      if (d !== 8'h01) begin
         bad++;
         $display("[TB] FAIL shift_status: got %02h, want 01", d);
      end
   endtask

   task automatic test_overrun;
      logic [7:0] d, e;
      logic oe;
      for (int i = 0; i < 9; i++) begin
         press_key(0, 1'b1, 1'b0, 8'h1C);
         if (i < 8) exp_q.push_back(8'h61);
      end
      cpu_read(0, 8'h91, d, oe);
      total++;
      if (d !== 8'h13) begin
         bad++;
         $display("[TB] FAIL overrun_status: got %02h, want 13", d);
      end
      cpu_write(0, 8'h91, 8'h10);
      cpu_read(0, 8'h91, d, oe);
      total++;
      if (d !== 8'h03) begin
         bad++;
         $display("[TB] FAIL overrun_clear: got %02h, want 03", d);
      end
      // Key byte reaches the full FIFO on the same edge the read pops.
      @(negedge clk_sys);
      ps2_key_v[0] = {~ps2_key_v[0][10], 1'b1, 1'b0, 8'h2B};
      @(negedge clk_sys);
      io_addr_v[0] = 8'h90;
      io_rd_v[0]   = 1'b1;
      @(negedge clk_sys);
      d = io_dout_v[0];
      io_rd_v[0] = 1'b0;
      e = exp_q.pop_front();
      exp_q.push_back(8'h66);
      total++;
      if (d !== e) begin
         bad++;
         $display("[TB] FAIL full_pushpop_data: got %02h, want %02h", d, e);
      end
      repeat (3) @(negedge clk_sys);
      cpu_read(0, 8'h91, d, oe);
      total++;
      if (d !== 8'h03) begin
         bad++;
         $display("[TB] FAIL full_pushpop_status: got %02h, want 03", d);
      end
      for (int i = 0; i < 8; i++) begin
         cpu_read(0, 8'h90, d, oe);
         e = exp_q.pop_front();
         total++;
         if (d !== e) begin
            bad++;
            $display("[TB] FAIL drain[%0d]: got %02h, want %02h", i, d, e);
         end
      end
      total++;
      if (int_req_v[0] !== 1'b0) begin
         bad++;
         $display("[TB] FAIL drain_int: int_req=%b, want 0", int_req_v[0]);
      end
   endtask

   task automatic test_extended;
      logic [7:0] d, e;
      logic oe;
      press_key(0, 1'b1, 1'b1, 8'h75);
      exp_q.push_back(8'hE2);
      press_key(0, 1'b0, 1'b1, 8'h75);
      press_key(0, 1'b1, 1'b0, 8'h05);
      cpu_read(0, 8'h91, d, oe);
      total++;
      if (d !== 8'h03) begin
         bad++;
         $display("[TB] FAIL ext_status: got %02h, want 03", d);
      end
      cpu_read(0, 8'h90, d, oe);
      e = exp_q.pop_front();
      total++;
      if (d !== e) begin
         bad++;
         $display("[TB] FAIL ext_data: got %02h, want %02h", d, e);
      end
      cpu_read(0, 8'h91, d, oe);
      total++;
      if (d !== 8'h01) begin
         bad++;
         $display("[TB] FAIL unmapped_status: got %02h, want 01", d);
      end
   endtask

   // Events on consecutive cycles, including shift and release codes.
   task automatic test_back_to_back;
      logic [10:0] stim [11];
      logic [8:0]  want [11];
      logic [7:0]  d, e;
      logic oe;
      stim[0]  = {1'b0, 1'b1, 1'b0, 8'h16}; want[0]  = 9'h131;
      stim[1]  = {1'b0, 1'b1, 1'b0, 8'h59}; want[1]  = 9'h000;
      stim[2]  = {1'b0, 1'b1, 1'b0, 8'h1E}; want[2]  = 9'h140;
      stim[3]  = {1'b0, 1'b1, 1'b0, 8'h45}; want[3]  = 9'h129;
      stim[4]  = {1'b0, 1'b1, 1'b0, 8'h32}; want[4]  = 9'h142;
      stim[5]  = {1'b0, 1'b0, 1'b0, 8'h59}; want[5]  = 9'h000;
      stim[6]  = {1'b0, 1'b1, 1'b0, 8'h29}; want[6]  = 9'h120;
      stim[7]  = {1'b0, 1'b1, 1'b0, 8'h5A}; want[7]  = 9'h10D;
      stim[8]  = {1'b0, 1'b0, 1'b0, 8'h5A}; want[8]  = 9'h000;
      stim[9]  = {1'b0, 1'b1, 1'b0, 8'h66}; want[9]  = 9'h17F;
      stim[10] = {1'b0, 1'b1, 1'b1, 8'h6B}; want[10] = 9'h1E1;
      for (int i = 0; i < 11; i++) begin
         @(negedge clk_sys);
         ps2_key_v[0] = {~ps2_key_v[0][10], stim[i][9:0]};
         if (want[i][8]) exp_q.push_back(want[i][7:0]);
      end
      repeat (4) @(negedge clk_sys);
      for (int i = 0; i < 8; i++) begin
         cpu_read(0, 8'h90, d, oe);
         e = exp_q.pop_front();
         total++;
         if (d !== e) begin
            bad++;
            $display("[TB] FAIL b2b[%0d]: got %02h, want %02h", i, d, e);
         end
      end
      cpu_read(0, 8'h91, d, oe);
      total++;
      if (d !== 8'h01) begin
         bad++;
         $display("[TB] FAIL b2b_status: got %02h, want 01", d);
      end
   endtask

   task automatic test_reset_midway;
      logic [7:0] d;
      logic oe;
      @(negedge clk_sys);
      ps2_key_v[0] = {~ps2_key_v[0][10], 1'b1, 1'b0, 8'h1C};
      @(negedge clk_sys);
      reset_n_v[0] = 1'b0;
      @(negedge clk_sys);
      reset_n_v[0] = 1'b1;
      repeat (6) @(negedge clk_sys);
      total++;
      if (int_req_v[0] !== 1'b0) begin
         bad++;
         $display("[TB] FAIL midreset_int: int_req=%b, want 0", int_req_v[0]);
      end
      cpu_read(0, 8'h91, d, oe);
      total++;
      if (d !== 8'h01) begin
         bad++;
         $display("[TB] FAIL midreset_status: got %02h, want 01", d);
      end
   endtask

   // Instance 1 leaves reset here. Its counter reaches 99 during the cycle
   // after the 99th edge, so a toggle placed after edge 97 has its translated
   // byte valid in exactly that cycle.
   task automatic test_heartbeat;
      logic [7:0] d, e;
      logic oe;
      @(negedge clk_sys);
      reset_n_v[1] = 1'b1;
      repeat (97) @(posedge clk_sys);
      @(negedge clk_sys);
      ps2_key_v[1] = {~ps2_key_v[1][10], 1'b1, 1'b0, 8'h1C};
      exp_q.push_back(8'h61);
      exp_q.push_back(8'h95);
      repeat (6) @(negedge clk_sys);
      cpu_read(1, 8'h91, d, oe);
      total++;
      if (d !== 8'h03) begin
         bad++;
         $display("[TB] FAIL hb_status: got %02h, want 03", d);
      end
      for (int i = 0; i < 2; i++) begin
         cpu_read(1, 8'h90, d, oe);
         e = exp_q.pop_front();
         total++;
         if (d !== e) begin
            bad++;
            $display("[TB] FAIL hb_order[%0d]: got %02h, want %02h", i, d, e);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         reset_n_v[i] = 1'b0;
         ps2_key_v[i] = 11'h000;
         io_addr_v[i] = 8'h00;
         io_rd_v[i]   = 1'b0;
         io_wr_v[i]   = 1'b0;
         io_din_v[i]  = 8'h00;
      end
      test_reset;
      test_basic_key;
      test_shift;
      test_overrun;
      test_extended;
      test_back_to_back;
      test_reset_midway;
      test_heartbeat;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "[TB] time limit");
   end

endmodule
